// File: rtl/led_step_counter.sv
// led_step_counter: prescaled up/down LED counter driven by debounced
// direction (pmod[0]) and run/pause (pmod[1]) push buttons.
module led_step_counter #(
    parameter int unsigned DIVISOR         = 24'd12000000,
    parameter int unsigned LED_W           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       pmod,
    output logic [LED_W-1:0] led,
    output logic             tick,
    output logic             running,
    output logic             dir
);
    localparam int unsigned   CW      = $clog2(DIVISOR);
    localparam int unsigned   DW      = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIVISOR - 1);
    localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {RUN, PAUSE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         sync1_q, sync2_q, stable_q, stable_d, stable_dly_q, press;
    logic [1:0][DW-1:0] db_cnt_q, db_cnt_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [LED_W-1:0]   led_q, led_d;
    logic               dir_q, dir_d;

    // A level is accepted only after it differs from the stable level for DEBOUNCE_CYCLES clocks.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_MAX) begin
                stable_d[i] = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    // Tick uses the current dir and state; toggles at the same edge only affect later ticks.
    always_comb begin
        press   = stable_q & ~stable_dly_q;
        tick    = state_q == RUN && cnt_q == CNT_MAX;
        cnt_d   = state_q != RUN ? cnt_q : cnt_q == CNT_MAX ? '0 : cnt_q + 1'b1;
        led_d   = !tick ? led_q : dir_q ? led_q + 1'b1 : led_q - 1'b1;
        dir_d   = dir_q ^ press[0];
        state_d = press[1] ? (state_q == RUN ? PAUSE : RUN) : state_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            db_cnt_q     <= '0;
            cnt_q        <= '0;
            led_q        <= '0;
            dir_q        <= 1'b1;
            state_q      <= RUN;
        end else begin
            sync1_q      <= pmod;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            db_cnt_q     <= db_cnt_d;
            cnt_q        <= cnt_d;
            led_q        <= led_d;
            dir_q        <= dir_d;
            state_q      <= state_d;
        end
    end

    assign led     = led_q;
    assign running = state_q == RUN;
    assign dir     = dir_q;
endmodule
